banked_data_memory: RTL and testbench

BANKED_DATA_MEMORY -- requirements
Module: banked_data_memory

---
 rtl/banked_mem_pkg.sv | 24 ++
 rtl/banked_data_memory_mem_bank.sv | 45 ++++
 rtl/banked_data_memory.sv | 172 +++++++++++++++++
 tb/tb_banked_data_memory.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg
// Shared definitions for the banked data memory: the controller state
// encoding, default geometry, and the widths derived from that geometry.
package banked_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NBANKS = 3;
    localparam int DEF_ADDR_W = 17;

    // A single bank still needs one select bit so the decode slices stay legal.
    function automatic int bank_bits(input int nbanks);
        return (nbanks > 1) ? $clog2(nbanks) : 1;
    endfunction

    localparam int DEF_IDX_W  = $clog2(DEF_DEPTH);
    localparam int DEF_BANK_W = bank_bits(DEF_NBANKS);

endpackage

// File: rtl/banked_data_memory_mem_bank.sv
// mem_bank
// One bank of byte-enabled synchronous RAM with a registered read port.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable; only lanes with be=1 are written
//   be    - byte lane enables
//   addr  - word index within the bank
//   wdata - write data
//   re    - read enable; rdata updates on the following edge
//   rdata - registered read data (read-first on a same-address write)
module mem_bank #(
    parameter int    DATA_W      = 32,
    parameter int    DEPTH       = 16,
    parameter int    BANK_ID     = 0,
    parameter string INIT_PREFIX = ""
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [DATA_W/8-1:0]      be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    output logic [DATA_W-1:0]        rdata
);
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (be[b]) begin
                    mem_q[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
        if (re) begin
            rdata_q <= mem_q[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/banked_data_memory.sv
// banked_data_memory
// Word-addressed memory split into NBANKS banks (operand A, operand B,
// result) with a sequencer that zeroes CLEAR_BANK one word per cycle.
// Ports:
//   clk, reset            - clock and asynchronous active-high reset
//   memread, memwrite     - request strobes, held by the requester until ready
//   address, byte_en,
//   data_in               - request address, write lanes, write data
//   ready                 - high while idle; a request is taken when ready=1
//   data_out, rvalid      - read data (held between reads) and its valid pulse
//   err                   - pulse one cycle after an illegal request is taken
//   clear_start           - begin zeroing CLEAR_BANK (ignored while clearing)
//   busy, done            - clear in progress / clear-finished pulse
module banked_data_memory
    import banked_mem_pkg::*;
#(
    parameter int    DATA_W      = DEF_DATA_W,
    parameter int    DEPTH       = DEF_DEPTH,
    parameter int    NBANKS      = DEF_NBANKS,
    parameter int    ADDR_W      = DEF_ADDR_W,
    parameter int    CLEAR_BANK  = NBANKS - 1,
    parameter string INIT_PREFIX = ""
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                memread,
    input  logic                memwrite,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W/8-1:0] byte_en,
    input  logic [DATA_W-1:0]   data_in,
    output logic                ready,
    output logic [DATA_W-1:0]   data_out,
    output logic                rvalid,
    output logic                err,
    input  logic                clear_start,
    output logic                busy,
    output logic                done
);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int BANK_W  = bank_bits(NBANKS);
    localparam int TOP_LSB = IDX_W + BANK_W;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   counter_q, counter_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic [BANK_W-1:0]  rd_bank_q, rd_bank_d;
    logic [DATA_W-1:0]  hold_q, hold_d;

    logic [IDX_W-1:0]   idx;
    logic [BANK_W-1:0]  bank_sel;
    logic               upper_nz;
    logic               illegal;
    logic               accept;
    logic               req_we;
    logic               req_re;
    logic [DATA_W-1:0]  bank_rdata [NBANKS];
    logic [DATA_W-1:0]  rd_mux;

    assign idx      = address[IDX_W-1:0];
    assign bank_sel = address[TOP_LSB-1:IDX_W];

    generate
        if (ADDR_W > TOP_LSB) begin : g_upper
            assign upper_nz = |address[ADDR_W-1:TOP_LSB];
        end else begin : g_no_upper
            assign upper_nz = 1'b0;
        end
    endgenerate

    assign illegal = (32'(bank_sel) >= 32'(NBANKS)) || upper_nz || (memread && memwrite);
    assign ready   = (state_q == IDLE);
    assign accept  = ready && (memread || memwrite);
    assign busy    = (state_q == CLEAR);

    // The bank output register only carries fresh data in the rvalid cycle;
    // outside it data_out comes from a holding register so it survives later
    // bank reads/clears and can be forced to zero by reset.
    assign rd_mux   = bank_rdata[rd_bank_q];
    assign data_out = rvalid_q ? rd_mux : hold_q;
    assign rvalid   = rvalid_q;
    assign err      = err_q;
    assign done     = done_q;

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;
        done_d    = 1'b0;
        rd_bank_d = rd_bank_q;
        hold_d    = rvalid_q ? rd_mux : hold_q;
        req_we    = 1'b0;
        req_re    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        err_d = 1'b1;
                    end else if (memread) begin
                        req_re    = 1'b1;
                        rvalid_d  = 1'b1;
                        rd_bank_d = bank_sel;
                    end else begin
                        req_we = 1'b1;
                    end
                end
                // A coincident request was handled above; clearing starts
                // on the same edge and its first write lands next cycle.
                if (clear_start) begin
                    state_d   = CLEAR;
                    counter_d = '0;
                end
            end
            CLEAR: begin
                counter_d = counter_q + 1'b1;
                if (counter_q == IDX_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            rd_bank_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            done_q    <= done_d;
            rd_bank_q <= rd_bank_d;
            hold_q    <= hold_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NBANKS; gi++) begin : g_bank
            logic clr_here;
            logic sel_here;
            assign clr_here = (state_q == CLEAR) && (gi == CLEAR_BANK);
            assign sel_here = (bank_sel == BANK_W'(gi));

            mem_bank #(
                .DATA_W      (DATA_W),
                .DEPTH       (DEPTH),
                .BANK_ID     (gi),
                .INIT_PREFIX (INIT_PREFIX)
            ) u_bank (
                .clk   (clk),
                .we    (clr_here || (req_we && sel_here)),
                .be    (clr_here ? {(DATA_W/8){1'b1}} : byte_en),
                .addr  (clr_here ? counter_q : idx),
                .wdata (clr_here ? {DATA_W{1'b0}} : data_in),
                .re    (req_re && sel_here),
                .rdata (bank_rdata[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_banked_data_memory.sv
// tb_banked_data_memory
// Table of request vectors plus hand sequences for the clear sequencer,
// reset mid-clear and requests held across a clear. Read/err responses are
// predicted into a queue when a request is driven and checked by a monitor.
module tb_banked_data_memory;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [16:0] address = '0;
    logic [3:0]  byte_en = '0;
    logic [31:0] data_in = '0;
    logic        clear_start = 1'b0;
    logic        ready;
    logic [31:0] data_out;
    logic        rvalid;
    logic        err;
    logic        busy;
    logic        done;

    banked_data_memory dut (
        .clk         (clk),
        .reset       (reset),
        .memread     (memread),
        .memwrite    (memwrite),
        .address     (address),
        .byte_en     (byte_en),
        .data_in     (data_in),
        .ready       (ready),
        .data_out    (data_out),
        .rvalid      (rvalid),
        .err         (err),
        .clear_start (clear_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        int          due;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [16:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] last_rd = '0;
    vec_t        vecs[17];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        compared++;
        mismatched++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Response monitor: every rvalid/err must match the oldest prediction,
    // arrive on its due cycle, and carry the predicted data_out.
    always @(negedge clk) begin
        if (!reset) begin
            if (rvalid || err) begin
                if (sb_q.size() == 0) begin
                    fail_now($sformatf("unexpected_resp rvalid=%0b err=%0b", rvalid, err));
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("resp_cycle", 32'(cyc), 32'(mon_e.due));
                    chk("resp_kind_rvalid_err", 32'({rvalid, err}), mon_e.is_err ? 32'h1 : 32'h2);
                    chk("resp_data", data_out, mon_e.data);
                end
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                fail_now("missing_resp");
                void'(sb_q.pop_front());
            end
        end
    end

    // Drive one request at a negedge and hold it until ready; the prediction
    // is queued once ready is seen, since the following edge accepts it.
    task automatic do_req(input logic rd, input logic wr, input logic [16:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata,
                          input logic with_clear, output logic done_seen);
        int   waited;
        exp_t e;
        memread     = rd;
        memwrite    = wr;
        address     = addr;
        byte_en     = be;
        data_in     = wdata;
        clear_start = with_clear;
        waited = 0;
        while (!ready && waited < 64) begin
            @(negedge clk);
            waited++;
        end
        done_seen = done;
        if (!ready) begin
            fail_now("ready_timeout");
        end else if (exp_err) begin
            e.is_err = 1'b1;
            e.data   = last_rd;
            e.due    = cyc + 1;
            sb_q.push_back(e);
        end else if (rd) begin
            e.is_err = 1'b0;
            e.data   = exp_rdata;
            e.due    = cyc + 1;
            sb_q.push_back(e);
            last_rd  = exp_rdata;
        end
        @(negedge clk);
        memread     = 1'b0;
        memwrite    = 1'b0;
        clear_start = 1'b0;
    endtask

    task automatic rd_exp(input logic [16:0] addr, input logic [31:0] exp);
        logic ds;
        do_req(1'b1, 1'b0, addr, 4'h0, 32'h0, 1'b0, exp, 1'b0, ds);
    endtask

    task automatic wr_word(input logic [16:0] addr, input logic [31:0] d);
        logic ds;
        do_req(1'b0, 1'b1, addr, 4'hF, d, 1'b0, 32'h0, 1'b0, ds);
    endtask

    task automatic preload_bank2();
        for (int i = 0; i < 16; i++) wr_word(17'h20 + 17'(i), 32'hC0DE0000 | 32'(i));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin : main
        logic ds;
        int   busy_cnt;
        int   done_cnt;
        int   rdy_bad;
        int   done_busy;
        int   n;

        // rd, wr, addr, be, wdata, exp_err, exp_rdata
        vecs[0]  = '{1'b0, 1'b1, 17'h00012, 4'hF, 32'h00000009, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 17'h00012, 4'h0, 32'h0,        1'b0, 32'h00000009};
        vecs[2]  = '{1'b0, 1'b1, 17'h00003, 4'hF, 32'hAABBCCDD, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 17'h00003, 4'h5, 32'h11223344, 1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 17'h00003, 4'h0, 32'h0,        1'b0, 32'hAA22CC44};
        vecs[5]  = '{1'b1, 1'b0, 17'h00030, 4'h0, 32'h0,        1'b1, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, 17'h00003, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, 17'h00003, 4'h0, 32'h0,        1'b0, 32'hAA22CC44};
        vecs[8]  = '{1'b0, 1'b1, 17'h00003, 4'h0, 32'h00000000, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 17'h00003, 4'h0, 32'h0,        1'b0, 32'hAA22CC44};
        vecs[10] = '{1'b0, 1'b1, 17'h00000, 4'hF, 32'h00F00F00, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 1'b1, 17'h00040, 4'hF, 32'hDEADBEEF, 1'b1, 32'h0};
        vecs[12] = '{1'b1, 1'b0, 17'h00000, 4'h0, 32'h0,        1'b0, 32'h00F00F00};
        vecs[13] = '{1'b0, 1'b1, 17'h0001F, 4'hF, 32'h55AA55AA, 1'b0, 32'h0};
        vecs[14] = '{1'b1, 1'b0, 17'h0001F, 4'h0, 32'h0,        1'b0, 32'h55AA55AA};
        vecs[15] = '{1'b1, 1'b0, 17'h00012, 4'h0, 32'h0,        1'b0, 32'h00000009};
        vecs[16] = '{1'b1, 1'b0, 17'h10012, 4'h0, 32'h0,        1'b1, 32'h0};

        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rvalid_err_done", 32'({rvalid, err, done}), 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) begin
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be, vecs[i].wdata,
                   vecs[i].exp_err, vecs[i].exp_rdata, 1'b0, ds);
        end
        repeat (3) @(negedge clk);
        chk("data_out_hold", data_out, last_rd);

        // Clear with bank 2 preloaded.
        preload_bank2();
        rd_exp(17'h20, 32'hC0DE0000);
        rd_exp(17'h2F, 32'hC0DE000F);
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        busy_cnt = 0; done_cnt = 0; rdy_bad = 0; done_busy = 0;
        for (int i = 0; i < 24; i++) begin
            if (busy) busy_cnt++;
            if (ready == busy) rdy_bad++;
            if (done) begin
                done_cnt++;
                if (busy) done_busy++;
            end
            @(negedge clk);
        end
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd16);
        chk("clear_done_pulses", 32'(done_cnt), 32'd1);
        chk("clear_ready_vs_busy", 32'(rdy_bad), 32'd0);
        chk("clear_done_while_busy", 32'(done_busy), 32'd0);
        for (int i = 0; i < 16; i++) rd_exp(17'h20 + 17'(i), 32'h0);
        rd_exp(17'h12, 32'h00000009);
        rd_exp(17'h03, 32'hAA22CC44);
        rd_exp(17'h00, 32'h00F00F00);
        rd_exp(17'h1F, 32'h55AA55AA);

        // Request coinciding with clear_start: both take effect.
        do_req(1'b0, 1'b1, 17'h05, 4'hF, 32'h5A5A5A5A, 1'b0, 32'h0, 1'b1, ds);
        chk("coincident_busy", 32'(busy), 32'h1);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) fail_now("coincident_done_timeout");
        rd_exp(17'h05, 32'h5A5A5A5A);

        // Request held across a clear is taken right after done.
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        chk("held_busy", 32'(busy), 32'h1);
        do_req(1'b1, 1'b0, 17'h12, 4'h0, 32'h0, 1'b0, 32'h00000009, 1'b0, ds);
        chk("held_accept_at_done", 32'(ds), 32'h1);

        // Reset after clear indices 0..4 have been written.
        preload_bank2();
        clear_start = 1'b1;
        @(negedge clk);
        clear_start = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midclr_rst_busy_ready", 32'({busy, ready}), 32'h1);
        chk("midclr_rst_rvalid_err_done", 32'({rvalid, err, done}), 32'h0);
        chk("midclr_rst_data_out", data_out, 32'h0);
        last_rd = 32'h0;
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (done || busy) n++;
            @(negedge clk);
        end
        chk("midclr_no_done_after_rst", 32'(n), 32'h0);
        for (int i = 0; i < 16; i++) begin
            rd_exp(17'h20 + 17'(i), (i < 5) ? 32'h0 : (32'hC0DE0000 | 32'(i)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
